// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 serial transmitter with a small TX FIFO.
// Registers (Addr[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 DIV.
module uart_tx_dev #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        TxD
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf, r_txen, r_irqen;
  logic [15:0]     r_div;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic [15:0]     r_baud;

  logic            w_sel_data, w_sel_stat, w_sel_ctrl, w_sel_div;
  logic            w_full, w_empty, w_push, w_pop, w_baud_zero, w_busy;
  logic [15:0]     w_div_m1;
  logic [4:0]      w_cnt5;
  logic            w_unused;

  assign w_sel_data  = WE && (Addr[1:0] == 2'd0);
  assign w_sel_stat  = WE && (Addr[1:0] == 2'd1);
  assign w_sel_ctrl  = WE && (Addr[1:0] == 2'd2);
  assign w_sel_div   = WE && (Addr[1:0] == 2'd3);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  // Fullness uses the pre-cycle count, so a push into a full FIFO drops even if a pop happens now.
  assign w_push      = w_sel_data && !w_full;
  assign w_pop       = (r_state == S_IDLE) && r_txen && !w_empty;
  assign w_baud_zero = (r_baud == 16'd0);
  // A stored DIV of 0 behaves like 1: reload value 0 gives a one-clock bit.
  assign w_div_m1    = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
  assign w_cnt5      = 5'(r_count);
  assign w_unused    = &{1'b0, Addr[29:2], Din[31:16]};

  // FIFO storage; stale entries are harmless because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= Din[7:0];
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Control, divisor and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txen  <= 1'b0;
      r_irqen <= 1'b0;
      r_div   <= DIV_RESET;
      r_ovf   <= 1'b0;
    end else begin
      if (w_sel_data && w_full) r_ovf <= 1'b1;
      else if (w_sel_stat)      r_ovf <= 1'b0;
      if (w_sel_ctrl) begin
        r_txen  <= Din[0];
        r_irqen <= Din[1];
      end
      if (w_sel_div) r_div <= Din[15:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_nxt = S_START;
      S_START: if (w_baud_zero) w_state_nxt = S_DATA;
      S_DATA:  if (w_baud_zero && (r_bitcnt == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_baud_zero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register, bit counter and baud counter; DIV is resampled at every bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift  <= 8'd0;
      r_bitcnt <= 3'd0;
      r_baud   <= 16'd0;
    end else if (r_state == S_IDLE) begin
      if (w_pop) begin
        r_shift  <= r_mem[r_rptr];
        r_bitcnt <= 3'd0;
        r_baud   <= w_div_m1;
      end
    end else if (w_baud_zero) begin
      r_baud <= w_div_m1;
      if (r_state == S_DATA) begin
        r_shift  <= r_shift >> 1;
        r_bitcnt <= r_bitcnt + 3'd1;
      end
    end else begin
      r_baud <= r_baud - 16'd1;
    end
  end

  // FSM outputs: serial line level and busy flag.
  always_comb begin
    TxD    = 1'b1;
    w_busy = 1'b1;
    case (r_state)
      S_IDLE:  w_busy = 1'b0;
      S_START: TxD    = 1'b0;
      S_DATA:  TxD    = r_shift[0];
      S_STOP:  TxD    = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  assign IRQ = r_irqen && w_empty && (r_state == S_IDLE);

  // Read mux; reads have no side effects.
  always_comb begin
    Dout = 32'd0;
    case (Addr[1:0])
      2'd1:    Dout = {23'd0, w_cnt5, r_ovf, w_empty, w_full, w_busy};
      2'd2:    Dout = {30'd0, r_irqen, r_txen};
      2'd3:    Dout = {16'd0, r_div};
      default: Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Bench for uart_tx_dev: directed register checks plus randomized frames compared
// against a per-clock waveform model built from the 8N1 framing rules.
module tb_uart_tx_dev;
  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        TxD;

  always #5 clk = ~clk;

  uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ), .TxD(TxD)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct packed { logic txd; logic busy; logic irq; } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] mk_addr(input logic [1:0] a);
    return {28'($urandom), a};
  endfunction

  // Compare one clock of the expected waveform; busy needs a STATUS read.
  task automatic cyc_check(input bit with_busy);
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("txd", {31'd0, TxD}, {31'd0, e.txd});
    chk("irq", {31'd0, IRQ}, {31'd0, e.irq});
    if (with_busy) chk("busy", {31'd0, Dout[0]}, {31'd0, e.busy});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      Addr = mk_addr(2'd1);
      #1;
      cyc_check(1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = mk_addr(a);
    Din  = d;
    WE   = 1'b1;
    #1;
    cyc_check(1'b0);
    @(posedge clk); #1;
    WE  = 1'b0;
    Din = $urandom;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = mk_addr(a);
    #1;
    chk(tag, Dout, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    WE    = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
  endtask

  // Waveform model: one idle clock after the enabling write, then each byte as
  // 10 bits of div clocks (start 0, data LSB first, stop 1), one idle clock
  // between frames, then idle with IRQ = irqen once the FIFO has drained.
  task automatic build(input int div, input logic [7:0] bytes[$], input bit irqen, input int tail);
    logic v;
    q.push_back('{txd: 1'b1, busy: 1'b0, irq: 1'b0});
    for (int i = 0; i < bytes.size(); i++) begin
      for (int b = 0; b < 10; b++) begin
        v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bytes[i][b-1];
        repeat (div) q.push_back('{txd: v, busy: 1'b1, irq: 1'b0});
      end
      if (i != bytes.size() - 1) q.push_back('{txd: 1'b1, busy: 1'b0, irq: 1'b0});
    end
    repeat (tail) q.push_back('{txd: 1'b1, busy: 1'b0, irq: irqen});
  endtask

  initial begin
    logic [7:0] bq[$];
    int div, n;
    bit irqen;
    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;

    // Reset state
    rd_chk("rst_status", 2'd1, 32'h4);
    rd_chk("rst_div", 2'd3, 32'd434);
    rd_chk("rst_ctrl", 2'd2, 32'h0);
    rd_chk("rst_data", 2'd0, 32'h0);
    chk("rst_txd", {31'd0, TxD}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);

    // Single A5 frame at DIV=4
    wr(2'd3, 32'd4);
    rd_chk("div4", 2'd3, 32'd4);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h0000_00A5);
    bq = '{8'hA5};
    build(4, bq, 1'b0, 4);
    step(q.size());

    // FIFO fill, overflow, overflow clear
    wr(2'd2, 32'h0);
    for (int i = 0; i < 4; i++) wr(2'd0, $urandom);
    rd_chk("full4", 2'd1, 32'h42);
    wr(2'd0, $urandom);
    rd_chk("ovf5", 2'd1, 32'h4A);
    wr(2'd1, $urandom);
    rd_chk("ovf_clr", 2'd1, 32'h42);

    // Back-to-back frames with IRQ, DIV=2
    do_reset();
    wr(2'd3, 32'd2);
    wr(2'd0, 32'h01);
    wr(2'd0, 32'h02);
    wr(2'd2, 32'h3);
    bq = '{8'h01, 8'h02};
    build(2, bq, 1'b1, 4);
    step(q.size());
    wr(2'd0, 32'h55);
    chk("irq_drop", {31'd0, IRQ}, 32'd0);

    // TXEN cleared mid-frame
    do_reset();
    wr(2'd3, 32'd4);
    wr(2'd0, 32'h3C);
    wr(2'd0, 32'hC3);
    wr(2'd2, 32'h1);
    bq = '{8'h3C};
    build(4, bq, 1'b0, 8);
    step(8);
    wr(2'd2, 32'h0);
    step(q.size());
    rd_chk("txen_off_cnt", 2'd1, 32'h10);
    chk("txen_off_txd", {31'd0, TxD}, 32'd1);

    // Reset during a data bit, then DIV=0 behaves as 1
    do_reset();
    wr(2'd3, 32'd4);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h00);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_txd_low", {31'd0, TxD}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_txd", {31'd0, TxD}, 32'd1);
    rd_chk("mid_rst_status", 2'd1, 32'h4);
    rd_chk("mid_rst_div", 2'd3, 32'd434);
    wr(2'd3, 32'd0);
    rd_chk("div0", 2'd3, 32'd0);
    wr(2'd2, 32'h1);
    bq = '{8'($urandom)};
    wr(2'd0, {24'd0, bq[0]});
    build(1, bq, 1'b0, 3);
    step(q.size());

    // Randomized streams
    for (int it = 0; it < 4; it++) begin
      do_reset();
      div   = $urandom_range(1, 5);
      n     = $urandom_range(1, 4);
      irqen = 1'($urandom);
      bq.delete();
      wr(2'd3, {$urandom_range(0, 65535), 16'(div)});
      for (int i = 0; i < n; i++) begin
        bq.push_back(8'($urandom));
        wr(2'd0, {$urandom_range(0, 16777215), bq[i]});
      end
      wr(2'd2, {30'd0, irqen, 1'b1});
      build(div, bq, irqen, 3);
      step(q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
